// File: rtl/sparse_sample_player.sv
// Sparse sample player: rebuilds a dense, time-aligned sample stream from
// {start_time, run_length} descriptors and the run sample words.
//
// state | meaning
// IDLE  | stopped, timer held at 0, output invalid
// FETCH | waiting for the prefetch entry to hold a run descriptor
// WAIT  | run loaded, waiting for the timer to reach its start_time
// PLAY  | consuming one sample word per cycle for run_length cycles
// DONE  | final run finished, timer frozen, output zero
//
// Every start_time compare uses the timer value of the cycle that would be
// spent in PLAY (timer_q + 1 when deciding one cycle ahead). This keeps sample
// k of a run in PLAY exactly when timer == start_time + k, so the registered
// output appears one cycle later.
module sparse_sample_player #(
  parameter int SAMPLE_WIDTH     = 16,
  parameter int PARALLEL_SAMPLES = 1,
  parameter int CLOCK_WIDTH      = 48,
  parameter int LENGTH_WIDTH     = 16
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic                                     timestamps_in_valid_i,
  output logic                                     timestamps_in_ready_o,
  input  logic [CLOCK_WIDTH+LENGTH_WIDTH-1:0]      timestamps_in_data_i,
  input  logic                                     timestamps_in_last_i,
  input  logic                                     samples_in_valid_i,
  output logic                                     samples_in_ready_o,
  input  logic [SAMPLE_WIDTH*PARALLEL_SAMPLES-1:0] samples_in_data_i,
  input  logic                                     start_stop_valid_i,
  output logic                                     start_stop_ready_o,
  input  logic [1:0]                               start_stop_data_i,
  output logic                                     data_out_valid_o,
  output logic [SAMPLE_WIDTH*PARALLEL_SAMPLES-1:0] data_out_data_o,
  output logic                                     playback_done,
  output logic                                     underflow,
  output logic                                     late
);

  localparam int DW = SAMPLE_WIDTH * PARALLEL_SAMPLES;
  localparam logic [CLOCK_WIDTH-1:0]  T_ONE  = CLOCK_WIDTH'(1);
  localparam logic [LENGTH_WIDTH-1:0] L_ONE  = LENGTH_WIDTH'(1);
  localparam logic [LENGTH_WIDTH-1:0] L_ZERO = '0;

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, PLAY, DONE} state_e;

  state_e                  state_q, state_d;
  logic [CLOCK_WIDTH-1:0]  timer_q, timer_d, next_time;
  logic                    ent_valid_q, ent_valid_d, ent_last_q, ent_last_d;
  logic [CLOCK_WIDTH-1:0]  ent_time_q, ent_time_d;
  logic [LENGTH_WIDTH-1:0] ent_len_q, ent_len_d;
  logic [CLOCK_WIDTH-1:0]  run_time_q, run_time_d;
  logic [LENGTH_WIDTH-1:0] rem_q, rem_d;
  logic                    run_last_q, run_last_d;
  logic [DW-1:0]           data_q, data_d;
  logic                    done_q, done_d, under_q, under_d, late_q, late_d;
  logic                    active, start_cmd, stop_cmd, launch;

  assign active    = (state_q == FETCH) || (state_q == WAIT) || (state_q == PLAY);
  assign start_cmd = start_stop_valid_i & start_stop_data_i[1];
  assign stop_cmd  = start_stop_valid_i & start_stop_data_i[0];
  assign next_time = timer_q + T_ONE;

  assign timestamps_in_ready_o = active & ~ent_valid_q;
  assign samples_in_ready_o    = (state_q == PLAY) & ~stop_cmd;
  assign start_stop_ready_o    = 1'b1;
  assign data_out_valid_o      = (state_q != IDLE);
  assign data_out_data_o       = data_q;
  assign playback_done         = done_q;
  assign underflow             = under_q;
  assign late                  = late_q;

  // Next-state, prefetch, run bookkeeping and output data selection.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    ent_valid_d = ent_valid_q;
    ent_time_d  = ent_time_q;
    ent_len_d   = ent_len_q;
    ent_last_d  = ent_last_q;
    run_time_d  = run_time_q;
    rem_d       = rem_q;
    run_last_d  = run_last_q;
    data_d      = '0;
    done_d      = done_q;
    under_d     = under_q;
    late_d      = late_q;
    launch      = 1'b0;

    if (active) timer_d = next_time;

    if (timestamps_in_ready_o && timestamps_in_valid_i) begin
      ent_valid_d = 1'b1;
      ent_time_d  = timestamps_in_data_i[CLOCK_WIDTH+LENGTH_WIDTH-1:LENGTH_WIDTH];
      ent_len_d   = timestamps_in_data_i[LENGTH_WIDTH-1:0];
      ent_last_d  = timestamps_in_last_i;
    end

    case (state_q)
      FETCH: begin
        if (ent_valid_q) begin
          if (ent_len_q == L_ZERO) begin
            ent_valid_d = 1'b0;
            if (ent_last_q) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end else begin
            launch = 1'b1;
          end
        end
      end
      WAIT: begin
        if (next_time == run_time_q) state_d = PLAY;
      end
      PLAY: begin
        if (samples_in_valid_i) data_d = samples_in_data_i;
        else                    under_d = 1'b1;
        rem_d = rem_q - L_ONE;
        if (rem_q == L_ONE) begin
          if (run_last_q) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else if (ent_valid_q && (ent_len_q != L_ZERO)) begin
            launch = 1'b1;
          end else begin
            // Zero-length leftovers are discarded by FETCH.
            state_d = FETCH;
          end
        end
      end
      default: ;
    endcase

    if (launch) begin
      ent_valid_d = 1'b0;
      run_time_d  = ent_time_q;
      rem_d       = ent_len_q;
      run_last_d  = ent_last_q;
      if (ent_time_q <= next_time) begin
        state_d = PLAY;
        if (ent_time_q < next_time) late_d = 1'b1;
      end else begin
        state_d = WAIT;
      end
    end

    if (start_cmd && ((state_q == IDLE) || (state_q == DONE))) begin
      state_d     = FETCH;
      timer_d     = '0;
      ent_valid_d = 1'b0;
      done_d      = 1'b0;
      under_d     = 1'b0;
      late_d      = 1'b0;
    end

    // Stop wins over a simultaneous start.
    if (stop_cmd) begin
      state_d     = IDLE;
      timer_d     = '0;
      ent_valid_d = 1'b0;
      data_d      = '0;
    end
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      ent_valid_q <= 1'b0;
      ent_time_q  <= '0;
      ent_len_q   <= '0;
      ent_last_q  <= 1'b0;
      run_time_q  <= '0;
      rem_q       <= '0;
      run_last_q  <= 1'b0;
      data_q      <= '0;
      done_q      <= 1'b0;
      under_q     <= 1'b0;
      late_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      ent_valid_q <= ent_valid_d;
      ent_time_q  <= ent_time_d;
      ent_len_q   <= ent_len_d;
      ent_last_q  <= ent_last_d;
      run_time_q  <= run_time_d;
      rem_q       <= rem_d;
      run_last_q  <= run_last_d;
      data_q      <= data_d;
      done_q      <= done_d;
      under_q     <= under_d;
      late_q      <= late_d;
    end
  end

endmodule

// File: doc/sparse_sample_player.md
SPARSE_SAMPLE_PLAYER -- requirements
Module: sparse_sample_player

Interface
REQ-001 SHALL have parameter SAMPLE_WIDTH, default 16, bits per sample.
REQ-002 SHALL have parameter PARALLEL_SAMPLES, default 1, samples per clock.
REQ-003 SHALL have parameter CLOCK_WIDTH, default 48, width of the start_time field.
REQ-004 SHALL have parameter LENGTH_WIDTH, default 16, width of the run_length field.
REQ-005 SHALL have port clk, input, 1, the single clock.
REQ-006 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port timestamps_in, Axis_If.Slave, CLOCK_WIDTH+LENGTH_WIDTH, {start_time, run_length} per run.
REQ-008 SHALL have port samples_in, Axis_If.Slave, SAMPLE_WIDTH*PARALLEL_SAMPLES, run sample words in order.
REQ-009 SHALL have port start_stop, Axis_If.Slave, 2, {start, stop}; ready tied to 1.
REQ-010 SHALL have port data_out, Realtime_If.Master, SAMPLE_WIDTH*PARALLEL_SAMPLES, reconstructed dense waveform.
REQ-011 SHALL have port playback_done, output, 1, sticky high after the final run completes.
REQ-012 SHALL have port underflow, output, 1, sticky; a sample word was missing during a run.
REQ-013 SHALL have port late, output, 1, sticky; a run started after its start_time.

Function
REQ-014 SHALL implement states IDLE, FETCH, WAIT, PLAY, DONE.
REQ-015 SHALL keep timer (CLOCK_WIDTH bits) at 0 in IDLE; SHALL clear it on start and increment by 1 every cycle outside IDLE/DONE, wrapping modulo 2^CLOCK_WIDTH.
REQ-016 SHALL, on start_stop.ok with start=1 in IDLE or DONE, clear the sticky flags and go to FETCH.
REQ-017 SHALL, on start_stop.ok with stop=1 in any state, go to IDLE and discard the prefetch entry; stop SHALL win over a simultaneous start.
REQ-018 SHALL hold one-entry prefetch register; timestamps_in.ready = ~entry_valid outside IDLE/DONE, 0 in IDLE/DONE.
REQ-019 SHALL, in FETCH with entry valid, load the run (start_time, length, last flag) and go to WAIT, or go directly to PLAY if start_time <= timer.
REQ-020 SHALL set late when a run enters PLAY with start_time < timer.
REQ-021 SHALL, in WAIT, go to PLAY in the cycle timer == start_time.
REQ-022 SHALL discard a run_length=0 entry without playing; if it carried last, go to DONE.
REQ-023 SHALL, in PLAY, assert samples_in.ready and consume one word per cycle for exactly run_length cycles.
REQ-024 SHALL output sample k of a run on data_out.data exactly one cycle after timer == start_time+k (registered, latency 1).
REQ-025 SHALL drive data_out.data = 0 in every cycle not carrying a played sample.
REQ-026 SHALL, if samples_in.valid=0 in a PLAY cycle, output 0, still decrement the remaining count, and set underflow.
REQ-027 SHALL, after the final sample of a run: if that run carried last, go to DONE; else if next entry valid, chain directly (PLAY if start_time <= timer+1, else WAIT) without a gap cycle; else FETCH.
REQ-028 SHALL set playback_done on entering DONE; data_out.data = 0 in DONE.
REQ-029 SHALL assert data_out.valid = 1 in every state except IDLE.
REQ-030 SHALL ignore samples_in.last.

Reset
REQ-031 SHALL on reset_n=0 asynchronously enter IDLE, clear timer, prefetch entry, playback_done, underflow, late, data_out.data and data_out.valid.
REQ-032 SHALL resume only on a new start after reset_n deasserts, discarding any in-flight run.

Verification
REQ-033 Start; ts {10,3,last}; samples A,B,C valid -> data_out zero until A,B,C at cycles after timer 10,11,12; playback_done next.
REQ-034 Back-to-back ts {5,2},{7,2,last} -> four contiguous samples, no gap cycle, late=0.
REQ-035 ts {3,4,last} delivered when timer=8 -> playback begins immediately; late=1; four samples played.
REQ-036 samples_in.valid low on 2nd of 3 samples -> output A,0,B; underflow=1; stream stays time-aligned.
REQ-037 ts {20,0},{25,1,last} -> no output at 20; one sample after timer 25; playback_done=1.
REQ-038 reset_n low mid-PLAY -> all outputs 0 immediately; start+stop in same cycle -> IDLE.
